penentu_state_block: RTL and testbench
======================================

Name: penentu_state_block

Overview:
- Grid-world state-transition block for the Q-learning datapath.
- Takes the agent's current state index and the selected action, and produces the next state index.
- 6-bit state = 8x8 grid, row-major: row = state[5:3], col = state[2:0].
- Output is registered; it feeds the reward lookup and Q-table address logic downstream.

Parameters:
- OBSTACLE_MASK, 64'h0, bit i set = cell i is blocked; a move into a blocked cell leaves the state unchanged.
- GOAL_STATE, 6'd63, absorbing terminal cell; every action from this cell returns GOAL_STATE.
- RESET_STATE, 6'd0, value of next_state while reset is asserted.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- current_state  in  6  present state index {row[2:0], col[2:0]}.
- at  in  4  action code.
- next_state  out  6  registered next state index.

Behaviour:
- Reset: while rst=1, next_state = RESET_STATE immediately (asynchronous). The first update happens on the first rising clk edge after rst deasserts.
- Latency: 1 cycle. On each rising clk edge, next_state <= f(current_state, at), where current_state and at are sampled at that edge. No handshake; the block updates every cycle.
- Action encoding:
  - 4'd0 UP: row-1
  - 4'd1 DOWN: row+1
  - 4'd2 LEFT: col-1
  - 4'd3 RIGHT: col+1
  - 4'd4..4'd15: invalid, f = current_state
- Boundaries: no wrap-around.
  - UP at row 0 -> unchanged; DOWN at row 7 -> unchanged.
  - LEFT at col 0 -> unchanged; RIGHT at col 7 -> unchanged.
- Obstacles: if the candidate cell has OBSTACLE_MASK[candidate] = 1, f = current_state.
- Goal: if current_state == GOAL_STATE, f = GOAL_STATE for every action. The goal check has priority over boundary and obstacle checks.
- Blocked start cell: if current_state is itself an obstacle cell, normal move rules still apply; the block does not enforce reachability.
- Arithmetic: row and col are computed separately as 3-bit values, with bounds checked before the increment or decrement. Carries never propagate between row and col.
- Reset mid-operation: rst asserted at any time forces next_state = RESET_STATE asynchronously. The in-flight computation is discarded.
- No X propagation from invalid actions; every action code maps to a defined result.

Decomposition:
- Shared package penentu_pkg holds:
  - STATE_W=6, ACT_W=4, GRID_DIM=8
  - action constants ACT_UP=0, ACT_DOWN=1, ACT_LEFT=2, ACT_RIGHT=3
  - a state_t typedef (6 bits) and an action_t typedef (4 bits)
- Sub-module: grid_move_comb, the purely combinational f(current_state, at) including boundary, obstacle and goal logic. The top level adds only the reset-able output register.

Test Plan:
- Basic moves from state 8 (row1,col0), no obstacles, one case per cycle:
  - at=1 -> 16 (6'b010000)
  - at=0 -> 0
  - at=2 -> 8 (wall)
  - at=3 -> 9
- Edges and invalid actions:
  - state 63 with GOAL_STATE overridden to 6'd62: at=1 -> 63, at=3 -> 63.
  - state 7: at=3 -> 7.
  - state 56: at=1 -> 56.
  - state 27: at=4..15 -> 27 each.
- Obstacle, with OBSTACLE_MASK bit 10 set: state 9, at=3 -> 9; state 2, at=1 -> 2; state 9, at=2 -> 8.
- Goal, with default GOAL_STATE=63: state 63, all four actions -> 63. Also state 62, at=3 -> 63.
- Reset and latency:
  - Assert rst mid-stream -> next_state = 0 with no clk edge.
  - Deassert rst, apply state 8, at=3 -> next_state stays 0 until the first rising edge, then becomes 9.
- Exhaustive sweep: all 64 states x 16 actions checked against a reference model, one cycle latency each.

Source files
------------

// File: rtl/penentu_state_block_pkg.sv
// Shared types and constants for the grid-world state-transition block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package penentu_pkg;

  localparam int STATE_W  = 6;
  localparam int ACT_W    = 4;
  localparam int GRID_DIM = 8;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [ACT_W-1:0]   action_t;

  localparam action_t ACT_UP    = 4'd0;
  localparam action_t ACT_DOWN  = 4'd1;
  localparam action_t ACT_LEFT  = 4'd2;
  localparam action_t ACT_RIGHT = 4'd3;

  // Highest row/column coordinate on the grid.
  localparam logic [2:0] MAX_IDX = 3'(GRID_DIM - 1);

  // Row-major packing: {row, col}.
  function automatic state_t pack_state(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/penentu_state_block_if.sv
// Bundles the state/action inputs and the registered next-state output.
// Latency: n/a (wiring only).
// Backpressure: none; the block consumes a new state/action every cycle.
// Ports: current_state, at (master -> slave); next_state (slave -> master).
interface penentu_state_block_if;
  import penentu_pkg::*;

  state_t  current_state;
  action_t at;
  state_t  next_state;

  modport master (output current_state, output at, input next_state);
  modport slave  (input current_state, input at, output next_state);

endinterface

// File: rtl/penentu_state_block_grid_move_comb.sv
// Combinational grid move f(current_state, at) with goal, wall and obstacle rules.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: current_state (in), at (in), next_state (out).
module grid_move_comb
  import penentu_pkg::*;
#(
  parameter logic [63:0] OBSTACLE_MASK = 64'h0,
  parameter state_t      GOAL_STATE    = 6'd63
) (
  input  state_t  current_state,
  input  action_t at,
  output state_t  next_state
);

  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] cand_row;
  logic [2:0] cand_col;
  logic       moved;
  state_t     cand;

  assign row = current_state[5:3];
  assign col = current_state[2:0];

  // Bounds are checked before the 3-bit add/sub, so row and col never wrap
  // and no carry can leak between the two fields.
  always_comb begin
    cand_row = row;
    cand_col = col;
    moved    = 1'b0;
    case (at)
      ACT_UP: begin
        if (row != 3'd0) begin
          cand_row = row - 3'd1;
          moved    = 1'b1;
        end
      end
      ACT_DOWN: begin
        if (row != MAX_IDX) begin
          cand_row = row + 3'd1;
          moved    = 1'b1;
        end
      end
      ACT_LEFT: begin
        if (col != 3'd0) begin
          cand_col = col - 3'd1;
          moved    = 1'b1;
        end
      end
      ACT_RIGHT: begin
        if (col != MAX_IDX) begin
          cand_col = col + 3'd1;
          moved    = 1'b1;
        end
      end
      default: begin
        moved = 1'b0;
      end
    endcase
  end

  assign cand = pack_state(cand_row, cand_col);

  // Goal is absorbing and wins over every other rule; a blocked start cell
  // is not special, only the destination is tested against the mask.
  always_comb begin
    next_state = current_state;
    if (current_state == GOAL_STATE) begin
      next_state = GOAL_STATE;
    end else if (moved && !OBSTACLE_MASK[cand]) begin
      next_state = cand;
    end
  end

endmodule

// File: rtl/penentu_state_block.sv
// Grid-world next-state generator for the Q-learning datapath, registered output.
// Latency: 1 cycle from current_state/at to next_state.
// Backpressure: none; updates every cycle, async reset forces RESET_STATE.
// Ports: clk, rst (async, active-high), bus (slave: current_state, at -> next_state).
module penentu_state_block
  import penentu_pkg::*;
#(
  parameter logic [63:0] OBSTACLE_MASK = 64'h0,
  parameter state_t      GOAL_STATE    = 6'd63,
  parameter state_t      RESET_STATE   = 6'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  penentu_state_block_if.slave  bus
);

  state_t move_nxt;

  grid_move_comb #(
    .OBSTACLE_MASK (OBSTACLE_MASK),
    .GOAL_STATE    (GOAL_STATE)
  ) u_move (
    .current_state (bus.current_state),
    .at            (bus.at),
    .next_state    (move_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.next_state <= RESET_STATE;
    end else begin
      bus.next_state <= move_nxt;
    end
  end

endmodule

// File: tb/tb_penentu_state_block.sv
// Directed bench for penentu_state_block: three parameterisations driven in lockstep.
// Latency: checks 1-cycle registered output and asynchronous reset.
// Backpressure: none.
module tb_penentu_state_block;
  import penentu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  penentu_state_block_if if_def ();
  penentu_state_block_if if_goal ();
  penentu_state_block_if if_obs ();

  // Default parameters.
  penentu_state_block dut_def (
    .clk (clk),
    .rst (rst),
    .bus (if_def.slave)
  );

  // Goal moved to 62, so 63 is an ordinary corner cell.
  penentu_state_block #(.GOAL_STATE(6'd62)) dut_goal (
    .clk (clk),
    .rst (rst),
    .bus (if_goal.slave)
  );

  // Cell 10 (row1,col2) is blocked.
  penentu_state_block #(.OBSTACLE_MASK(64'h0000_0000_0000_0400)) dut_obs (
    .clk (clk),
    .rst (rst),
    .bus (if_obs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input state_t obs, input state_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input state_t s, input action_t a);
    if_def.current_state  = s;
    if_def.at             = a;
    if_goal.current_state = s;
    if_goal.at            = a;
    if_obs.current_state  = s;
    if_obs.at             = a;
  endtask

  // Apply inputs, let one rising edge capture them, sample 1 time unit later.
  task automatic step(input state_t s, input action_t a);
    drive(s, a);
    @(posedge clk);
    #1;
  endtask

  // Independent reference using signed coordinates and explicit range checks.
  function automatic state_t ref_f(input state_t s, input action_t a,
                                   input logic [63:0] mask, input state_t goal);
    int r;
    int c;
    int nr;
    int nc;
    int cand;
    r  = int'(s) / 8;
    c  = int'(s) % 8;
    nr = r;
    nc = c;
    case (int'(a))
      0: nr = r - 1;
      1: nr = r + 1;
      2: nc = c - 1;
      3: nc = c + 1;
      default: ;
    endcase
    if (s == goal) return goal;
    if (nr < 0 || nr > 7 || nc < 0 || nc > 7) return s;
    cand = nr * 8 + nc;
    if (mask[cand]) return s;
    return state_t'(cand);
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(6'd0, 4'd0);
    #1;
    chk("reset_def",  if_def.next_state,  6'd0);
    chk("reset_goal", if_goal.next_state, 6'd0);
    chk("reset_obs",  if_obs.next_state,  6'd0);
    #12;
    rst = 1'b0;

    // Basic moves from state 8.
    step(6'd8, 4'd1); chk("s8_down",  if_def.next_state, 6'd16);
    step(6'd8, 4'd0); chk("s8_up",    if_def.next_state, 6'd0);
    step(6'd8, 4'd2); chk("s8_left",  if_def.next_state, 6'd8);
    step(6'd8, 4'd3); chk("s8_right", if_def.next_state, 6'd9);

    // Edges with goal relocated to 62.
    step(6'd63, 4'd1); chk("g62_s63_down",  if_goal.next_state, 6'd63);
    step(6'd63, 4'd3); chk("g62_s63_right", if_goal.next_state, 6'd63);
    step(6'd7,  4'd3); chk("s7_right",      if_def.next_state,  6'd7);
    step(6'd56, 4'd1); chk("s56_down",      if_def.next_state,  6'd56);
    for (int a = 4; a < 16; a++) begin
      step(6'd27, action_t'(a));
      chk($sformatf("s27_inv%0d", a), if_def.next_state, 6'd27);
    end

    // Obstacle at cell 10.
    step(6'd9, 4'd3); chk("obs_s9_right", if_obs.next_state, 6'd9);
    step(6'd2, 4'd1); chk("obs_s2_down",  if_obs.next_state, 6'd2);
    step(6'd9, 4'd2); chk("obs_s9_left",  if_obs.next_state, 6'd8);
    // Starting on the blocked cell still moves normally.
    step(6'd10, 4'd3); chk("obs_s10_right", if_obs.next_state, 6'd11);

    // Goal absorbing at default 63.
    for (int a = 0; a < 4; a++) begin
      step(6'd63, action_t'(a));
      chk($sformatf("goal_s63_a%0d", a), if_def.next_state, 6'd63);
    end
    step(6'd62, 4'd3); chk("s62_right_to_goal", if_def.next_state, 6'd63);
    step(6'd62, 4'd0); chk("g62_absorb_up",     if_goal.next_state, 6'd62);

    // Asynchronous reset mid-stream: raised 4 units after an edge.
    step(6'd20, 4'd3);
    chk("pre_reset", if_def.next_state, 6'd21);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_def", if_def.next_state, 6'd0);
    chk("async_rst_obs", if_obs.next_state, 6'd0);
    drive(6'd8, 4'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("hold_after_rst", if_def.next_state, 6'd0);
    @(posedge clk);
    #1;
    chk("first_edge", if_def.next_state, 6'd9);

    // Exhaustive sweep against the reference model.
    for (int s = 0; s < 64; s++) begin
      for (int a = 0; a < 16; a++) begin
        step(state_t'(s), action_t'(a));
        chk($sformatf("sweep_def_s%0d_a%0d", s, a), if_def.next_state,
            ref_f(state_t'(s), action_t'(a), 64'h0, 6'd63));
        chk($sformatf("sweep_goal_s%0d_a%0d", s, a), if_goal.next_state,
            ref_f(state_t'(s), action_t'(a), 64'h0, 6'd62));
        chk($sformatf("sweep_obs_s%0d_a%0d", s, a), if_obs.next_state,
            ref_f(state_t'(s), action_t'(a), 64'h0000_0000_0000_0400, 6'd63));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
